// File: rtl/vend_pkg.sv
// Shared constants and types for the dispenser sequencer.
package vend_pkg;

   localparam logic [1:0] POS_CLOSED = 2'b00;
   localparam logic [1:0] POS_OPEN   = 2'b01;
   localparam logic [1:0] GRANT_NONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      CLOSE = 2'd2
   } state_t;

   // Next requester index in round-robin order 0 -> 1 -> 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; search starts one past the last winner.
module rr_arbiter3
   import vend_pkg::*;
(
   input  logic [2:0] pending,
   input  logic [1:0] rr_ptr,
   output logic [1:0] winner,
   output logic       valid
);

   logic [1:0] idx;

   // Walk the three requesters starting after rr_ptr and keep the first pending one.
   always_comb begin
      winner = GRANT_NONE;
      valid  = 1'b0;
      idx    = rr_next(rr_ptr);
      for (int i = 0; i < 3; i++) begin
         if (!valid && pending[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
         idx = rr_next(idx);
      end
   end

endmodule

// File: rtl/dispense_sequencer.sv
// Serialises item and change dispenses so only one servo moves at a time.
// Change requests repeat nickel ejects until the credit owner reports zero.
module dispense_sequencer
   import vend_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int SETTLE_CYCLES = 25_000_000,
   parameter int CNT_W         = 27
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_item0,
   input  logic       req_item1,
   input  logic       req_change,
   input  logic       credit_nonzero,
   output logic       coin_out,
   output logic [1:0] motor_position0,
   output logic [1:0] motor_position1,
   output logic [1:0] motor_position2,
   output logic [1:0] grant,
   output logic       busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic [2:0]       pending;
   logic [2:0]       req_vec;
   logic [2:0]       grant_clear;
   logic [1:0]       rr_ptr;
   logic [1:0]       winner;
   logic             win_valid;

   assign req_vec = {req_change, req_item1, req_item0};

   rr_arbiter3 u_arb (
      .pending (pending),
      .rr_ptr  (rr_ptr),
      .winner  (winner),
      .valid   (win_valid)
   );

   // A pending bit is consumed only when the arbiter picks it in IDLE.
   always_comb begin
      grant_clear = 3'b000;
      if (state == IDLE && win_valid) begin
         grant_clear[winner] = 1'b1;
      end
   end

   // Pending bits: a new pulse in the same cycle as the grant keeps the bit set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= 3'b000;
      end else begin
         pending <= (pending & ~grant_clear) | req_vec;
      end
   end

   // Sequencer FSM with shared timer and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         timer           <= '0;
         rr_ptr          <= 2'd2;
         grant           <= GRANT_NONE;
         busy            <= 1'b0;
         coin_out        <= 1'b0;
         motor_position0 <= POS_CLOSED;
         motor_position1 <= POS_CLOSED;
         motor_position2 <= POS_CLOSED;
      end else begin
         coin_out <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  rr_ptr <= winner;
                  // Change with no credit left is simply dropped.
                  if (winner != 2'd2 || credit_nonzero) begin
                     state           <= OPEN;
                     timer           <= '0;
                     grant           <= winner;
                     busy            <= 1'b1;
                     motor_position0 <= (winner == 2'd0) ? POS_OPEN : POS_CLOSED;
                     motor_position1 <= (winner == 2'd1) ? POS_OPEN : POS_CLOSED;
                     motor_position2 <= (winner == 2'd2) ? POS_OPEN : POS_CLOSED;
                  end
               end
            end
            OPEN: begin
               if (timer == HOLD_LAST) begin
                  state           <= CLOSE;
                  timer           <= '0;
                  motor_position0 <= POS_CLOSED;
                  motor_position1 <= POS_CLOSED;
                  motor_position2 <= POS_CLOSED;
                  if (grant == 2'd2) begin
                     coin_out <= 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CLOSE: begin
               if (timer == SETTLE_LAST) begin
                  timer <= '0;
                  if (grant == 2'd2 && credit_nonzero) begin
                     state           <= OPEN;
                     motor_position2 <= POS_OPEN;
                  end else begin
                     state <= IDLE;
                     grant <= GRANT_NONE;
                     busy  <= 1'b0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state           <= IDLE;
               timer           <= '0;
               grant           <= GRANT_NONE;
               busy            <= 1'b0;
               motor_position0 <= POS_CLOSED;
               motor_position1 <= POS_CLOSED;
               motor_position2 <= POS_CLOSED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer with a nickel-per-coin credit model.
`timescale 1ns/1ps
module tb_dispense_sequencer;
   import vend_pkg::*;

   localparam int HOLD   = 4;
   localparam int SETTLE = 3;

   // Clock and reset
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_item0 = 1'b0;
   logic       req_item1 = 1'b0;
   logic       req_change = 1'b0;
   logic       credit_nonzero;
   logic       coin_out;
   logic [1:0] motor_position0;
   logic [1:0] motor_position1;
   logic [1:0] motor_position2;
   logic [1:0] grant;
   logic       busy;

   always #5 clock = ~clock;

   dispense_sequencer #(
      .HOLD_CYCLES   (HOLD),
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (27)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_item0       (req_item0),
      .req_item1       (req_item1),
      .req_change      (req_change),
      .credit_nonzero  (credit_nonzero),
      .coin_out        (coin_out),
      .motor_position0 (motor_position0),
      .motor_position1 (motor_position1),
      .motor_position2 (motor_position2),
      .grant           (grant),
      .busy            (busy)
   );

   // Credit owner: subtracts 5 for every reported coin.
   int credit = 0;
   assign credit_nonzero = (credit > 0);
   always @(posedge clock) begin
      if (!reset && coin_out) credit <= credit - 5;
   end

   // Scoreboard state
   int         n_pass = 0;
   int         n_total = 0;
   logic [1:0] exp_q[$];
   int         coin_cnt = 0;
   int         m0_opens = 0;
   int         m1_opens = 0;
   int         m2_opens = 0;
   bit         busy_seen = 1'b0;
   bit         mon_en = 1'b0;
   logic [1:0] prev_grant = GRANT_NONE;
   logic [1:0] prev_m0 = POS_CLOSED;
   logic [1:0] prev_m1 = POS_CLOSED;
   logic [1:0] prev_m2 = POS_CLOSED;

   task automatic check(input string name, input int actual, input int expected);
      n_total++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Monitor: grant order against exp_q, coin and servo-open counts, one-servo rule.
   always @(negedge clock) begin
      int         n_open;
      logic [1:0] e;
      if (mon_en) begin
         if (coin_out) begin
            coin_cnt++;
            check("coin_has_credit", int'(credit >= 5), 1);
         end
         if (motor_position0 == POS_OPEN && prev_m0 != POS_OPEN) m0_opens++;
         if (motor_position1 == POS_OPEN && prev_m1 != POS_OPEN) m1_opens++;
         if (motor_position2 == POS_OPEN && prev_m2 != POS_OPEN) m2_opens++;
         n_open = int'(motor_position0 == POS_OPEN) + int'(motor_position1 == POS_OPEN)
                + int'(motor_position2 == POS_OPEN);
         check("one_servo_open", int'(n_open <= 1), 1);
         if (busy) busy_seen = 1'b1;
         if (grant != prev_grant && grant != GRANT_NONE) begin
            if (exp_q.size() == 0) begin
               check("grant_unexpected", int'(grant), int'(GRANT_NONE));
            end else begin
               e = exp_q.pop_front();
               check("grant_order", int'(grant), int'(e));
            end
         end
      end
      prev_grant = grant;
      prev_m0    = motor_position0;
      prev_m1    = motor_position1;
      prev_m2    = motor_position2;
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input int which);
      req_item0  = (which == 0);
      req_item1  = (which == 1);
      req_change = (which == 2);
      tick();
      req_item0  = 1'b0;
      req_item1  = 1'b0;
      req_change = 1'b0;
   endtask

   task automatic clear_counts();
      coin_cnt  = 0;
      m0_opens  = 0;
      m1_opens  = 0;
      m2_opens  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic wait_open(input int which, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if ((which == 0 && motor_position0 == POS_OPEN) ||
             (which == 1 && motor_position1 == POS_OPEN) ||
             (which == 2 && motor_position2 == POS_OPEN)) found = 1'b1;
         else tick();
      end
      check(name, int'(found), 1);
   endtask

   task automatic wait_quiet(input string name);
      int quiet = 0;
      for (int i = 0; i < 400 && quiet < 4; i++) begin
         tick();
         if (!busy) quiet++;
         else quiet = 0;
      end
      check(name, int'(quiet >= 4), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_m0"}, int'(motor_position0), int'(POS_CLOSED));
      check({tag, "_m1"}, int'(motor_position1), int'(POS_CLOSED));
      check({tag, "_m2"}, int'(motor_position2), int'(POS_CLOSED));
      check({tag, "_grant"}, int'(grant), int'(GRANT_NONE));
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_coin"}, int'(coin_out), 0);
   endtask

   // Single item0 dispense, one row per cycle after the pulse cycle.
   typedef struct {
      logic       r0;
      logic [1:0] m0;
      logic [1:0] g;
      logic       b;
   } vec_t;
   vec_t tbl[11];

   initial begin
      // Table: pulse at cycle 0, open cycles 2..5, close 6..8, idle from 9.
      for (int k = 0; k < 11; k++) begin
         tbl[k].r0 = (k == 0);
         tbl[k].m0 = (k >= 2 && k <= 5) ? POS_OPEN : POS_CLOSED;
         tbl[k].g  = (k >= 2 && k <= 8) ? 2'd0 : GRANT_NONE;
         tbl[k].b  = (k >= 2 && k <= 8);
      end

      repeat (3) @(posedge clock);
      #1;
      check_idle_outputs("rst_init");
      reset  = 1'b0;
      mon_en = 1'b1;

      // 1: reset in the middle of an item1 dispense
      exp_q.push_back(2'd1);
      pulse(1);
      wait_open(1, "t1_open");
      tick();
      reset = 1'b1;
      #1;
      check_idle_outputs("t1_rst");
      tick();
      tick();
      reset = 1'b0;
      clear_counts();
      repeat (12) tick();
      check("t1_no_motion", m0_opens + m1_opens + m2_opens, 0);
      check("t1_busy_seen", int'(busy_seen), 0);
      check("t1_grant_consumed", exp_q.size(), 0);

      // 2: item0 cycle-by-cycle
      clear_counts();
      exp_q.push_back(2'd0);
      for (int k = 0; k < 11; k++) begin
         @(posedge clock);
         #1;
         req_item0 = tbl[k].r0;
         @(negedge clock);
         check($sformatf("t2_m0_c%0d", k), int'(motor_position0), int'(tbl[k].m0));
         check($sformatf("t2_grant_c%0d", k), int'(grant), int'(tbl[k].g));
         check($sformatf("t2_busy_c%0d", k), int'(busy), int'(tbl[k].b));
         check($sformatf("t2_coin_c%0d", k), int'(coin_out), 0);
      end
      req_item0 = 1'b0;
      tick();

      // 3: round robin: item1 before a repeated item0
      clear_counts();
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd0);
      pulse(0);
      wait_open(0, "t3_open0");
      req_item0 = 1'b1;
      req_item1 = 1'b1;
      tick();
      req_item0 = 1'b0;
      req_item1 = 1'b0;
      wait_quiet("t3_done");
      check("t3_grants_left", exp_q.size(), 0);
      check("t3_m0_opens", m0_opens, 2);
      check("t3_m1_opens", m1_opens, 1);
      check("t3_coins", coin_cnt, 0);

      // 4: change drain from 15
      credit = 15;
      clear_counts();
      exp_q.push_back(2'd2);
      pulse(2);
      wait_quiet("t4_done");
      check("t4_coins", coin_cnt, 3);
      check("t4_m2_opens", m2_opens, 3);
      check("t4_credit", credit, 0);
      check("t4_grant", int'(grant), int'(GRANT_NONE));
      check("t4_grants_left", exp_q.size(), 0);

      // 5: change with zero credit is dropped
      credit = 0;
      clear_counts();
      pulse(2);
      repeat (10) tick();
      check("t5_m2_opens", m2_opens, 0);
      check("t5_coins", coin_cnt, 0);
      check("t5_busy_seen", int'(busy_seen), 0);
      check("t5_grant", int'(grant), int'(GRANT_NONE));
      credit = 10;
      repeat (15) tick();
      check("t5_pending_cleared", m2_opens, 0);
      check("t5_busy_late", int'(busy_seen), 0);

      // 6: reset during the second OPEN cycle of change
      credit = 10;
      clear_counts();
      exp_q.push_back(2'd2);
      pulse(2);
      wait_open(2, "t6_open");
      tick();
      reset = 1'b1;
      #1;
      check_idle_outputs("t6_rst");
      repeat (2) tick();
      reset = 1'b0;
      clear_counts();
      repeat (15) tick();
      check("t6_coins", coin_cnt, 0);
      check("t6_credit", credit, 10);
      check("t6_m2_opens", m2_opens, 0);
      check("t6_busy_seen", int'(busy_seen), 0);
      check("t6_grants_left", exp_q.size(), 0);

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
